// File: rtl/sort4_ctrl_pkg.sv
// ============================================================================
// sort4_ctrl_pkg : shared types and sizes for the 4-entry bubble sorter
// Revision: 1.0
// ============================================================================
`default_nettype none

package sort4_ctrl_pkg;

  localparam int DEPTH    = 4;
  localparam int WIDTH    = 4;
  localparam int MAX_PASS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sort4_ctrl_cmp.sv
// ============================================================================
// sort4_ctrl_cmp : unsigned magnitude comparator for one entry pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module sort4_ctrl_cmp
  import sort4_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] DinA,
  input  logic [WIDTH-1:0] DinB,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  assign less    = (DinA <  DinB);
  assign equal   = (DinA == DinB);
  assign greater = (DinA >  DinB);

endmodule

`default_nettype wire

// File: rtl/sort4_ctrl.sv
// ============================================================================
// sort4_ctrl : load four 4-bit values, bubble-sort them ascending in place
// Revision: 1.0
// ============================================================================
`default_nettype none

module sort4_ctrl
  import sort4_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] Din,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       rd_idx,
  output logic [WIDTH-1:0] Dout,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swaps
);

  localparam logic [1:0] LAST_PASS = 2'(MAX_PASS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic             full_q, full_d;
  logic [1:0]       pass_q, pass_d;
  logic [1:0]       j_q, j_d;
  logic [2:0]       swaps_q, swaps_d;
  logic             swapped_q, swapped_d;

  logic [1:0]       w_jn;
  logic             w_lt, w_eq, w_gt;
  logic             w_swap;

  assign w_jn = j_q + 2'd1;

  sort4_ctrl_cmp u_cmp (
    .DinA    (entries_q[j_q]),
    .DinB    (entries_q[w_jn]),
    .less    (w_lt),
    .equal   (w_eq),
    .greater (w_gt)
  );

  // Equal values never swap, which keeps the sort stable.
  assign w_swap = w_gt & ~(w_lt | w_eq);

  always_comb begin
    state_d   = state_q;
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    pass_d    = pass_q;
    j_d       = j_q;
    swaps_d   = swaps_q;
    swapped_d = swapped_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          wr_ptr_d = 2'd0;
          full_d   = 1'b0;
        end else if (start && full_q) begin
          swaps_d   = 3'd0;
          pass_d    = 2'd0;
          j_d       = 2'd0;
          swapped_d = 1'b0;
          state_d   = SORT;
        end else if (load_valid && load_ready) begin
          entries_d[wr_ptr_q] = Din;
          wr_ptr_d            = wr_ptr_q + 2'd1;
          if (wr_ptr_q == 2'd3) full_d = 1'b1;
        end
      end
      SORT: begin
        if (w_swap) begin
          entries_d[j_q]  = entries_q[w_jn];
          entries_d[w_jn] = entries_q[j_q];
          swaps_d         = swaps_q + 3'd1;
        end
        if (j_q == 2'd2) begin
          j_d       = 2'd0;
          pass_d    = pass_q + 2'd1;
          swapped_d = 1'b0;
          // The final compare of the pass counts toward "this pass swapped".
          if (!(swapped_q || w_swap) || (pass_q == LAST_PASS)) state_d = DONE;
        end else begin
          j_d       = w_jn;
          swapped_d = swapped_q | w_swap;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q  <= 2'd0;
      full_q    <= 1'b0;
      pass_q    <= 2'd0;
      j_q       <= 2'd0;
      swaps_q   <= 3'd0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      pass_q    <= pass_d;
      j_q       <= j_d;
      swaps_q   <= swaps_d;
      swapped_q <= swapped_d;
    end
  end

  assign load_ready = (state_q == IDLE) && !full_q;
  assign busy       = (state_q == SORT);
  assign done       = (state_q == DONE);
  assign swaps      = swaps_q;
  assign Dout       = entries_q[rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
// ============================================================================
// tb_sort4_ctrl : scoreboard bench for sort4_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sort4_ctrl;

  logic       clk = 1'b0;
  logic       rst, load_valid, load_ready, start, clear, busy, done;
  logic [3:0] Din, Dout;
  logic [1:0] rd_idx;
  logic [2:0] swaps;

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic [3:0][3:0] e;
    logic [2:0]      sw;
    logic [4:0]      lat;
  } exp_t;

  exp_t sb_q[$];

  sort4_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .Din        (Din),
    .start      (start),
    .clear      (clear),
    .rd_idx     (rd_idx),
    .Dout       (Dout),
    .busy       (busy),
    .done       (done),
    .swaps      (swaps)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] a, b, c, d, input logic [2:0] sw,
                              input logic [4:0] lat);
    exp_t x;
    x.e   = {d, c, b, a};
    x.sw  = sw;
    x.lat = lat;
    return x;
  endfunction

  task automatic check_entries(input string tag, input logic [3:0][3:0] e);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), Dout, e[i]);
    end
  endtask

  task automatic load1(input logic [3:0] v);
    load_valid = 1'b1;
    Din        = v;
    chk("load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load4(input logic [3:0] a, b, c, d);
    load1(a); load1(b); load1(c); load1(d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Starts a sort and holds load/clear/Din noise while it runs; all of it must be ignored.
  task automatic sort_and_check(input exp_t x);
    exp_t want;
    int   n;
    sb_q.push_back(x);
    start = 1'b1;
    tick();
    start      = 1'b0;
    load_valid = 1'b1;
    Din        = 4'd0;
    clear      = 1'b1;
    n = 1;
    while (!done && n < 40) begin
      chk("busy_in_sort", busy, 1);
      tick();
      n++;
    end
    load_valid = 1'b0;
    clear      = 1'b0;
    want = sb_q.pop_front();
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, want.lat);
      chk("swaps", swaps, want.sw);
      chk("busy_at_done", busy, 0);
      check_entries("sorted", want.e);
    end
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_full_ready", load_ready, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; clear = 1'b0;
    Din = 4'd0; rd_idx = 2'd0;
    repeat (2) tick();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_swaps", swaps, 0);
    check_entries("rst_entry", '0);
    rst = 1'b0;
    tick();

    load4(4'd10, 4'd12, 4'd15, 4'd11);
    chk("full_ready", load_ready, 0);
    sort_and_check(mk(4'd10, 4'd11, 4'd12, 4'd15, 3'd2, 5'd10));

    do_clear();
    load4(4'd1, 4'd2, 4'd3, 4'd4);
    sort_and_check(mk(4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 5'd4));

    do_clear();
    load4(4'd15, 4'd12, 4'd10, 4'd1);
    sort_and_check(mk(4'd1, 4'd10, 4'd12, 4'd15, 3'd6, 5'd10));

    do_clear();
    load4(4'd10, 4'd10, 4'd10, 4'd10);
    sort_and_check(mk(4'd10, 4'd10, 4'd10, 4'd10, 3'd0, 5'd4));
    do_clear();
    chk("clear_ready", load_ready, 1);
    check_entries("clear_keeps", {4'd10, 4'd10, 4'd10, 4'd10});

    // Start with only two entries held must be ignored.
    load4(4'd7, 4'd3, 4'd0, 4'd0);
    do_clear();
    load1(4'd7);
    load1(4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("partial_busy", busy, 0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (busy || done) seen = 1'b1;
    end
    chk("partial_no_sort", seen, 0);
    load1(4'd9);
    load1(4'd5);
    chk("full_after4", load_ready, 0);
    load_valid = 1'b1;
    Din        = 4'd15;
    tick();
    load_valid = 1'b0;
    chk("fifth_ready", load_ready, 0);
    check_entries("fifth_unchanged", {4'd5, 4'd9, 4'd3, 4'd7});
    sort_and_check(mk(4'd3, 4'd5, 4'd7, 4'd9, 3'd3, 5'd10));
    sort_and_check(mk(4'd3, 4'd5, 4'd7, 4'd9, 3'd0, 5'd4));

    // Reset on the fifth SORT cycle.
    do_clear();
    load4(4'd15, 4'd12, 4'd10, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_swaps", swaps, 0);
    chk("mid_rst_ready", load_ready, 1);
    check_entries("mid_rst_entry", '0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (busy || done) seen = 1'b1;
    end
    chk("no_resume", seen, 0);
    chk("post_rst_ready", load_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port load_valid, input, 1 bit: Din is presented for loading.
REQ-004 SHALL have port load_ready, output, 1 bit: a load is accepted this cycle; high only in IDLE with fewer than 4 entries held.
REQ-005 SHALL have port Din, input, 4 bits: unsigned value to load.
REQ-006 SHALL have port start, input, 1 bit: request to sort the held entries.
REQ-007 SHALL have port clear, input, 1 bit: empty the buffer.
REQ-008 SHALL have port rd_idx, input, 2 bits: readback entry index.
REQ-009 SHALL have port Dout, output, 4 bits: combinational value of entry[rd_idx].
REQ-010 SHALL have port busy, output, 1 bit: high while state is SORT.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sort completes.
REQ-012 SHALL have port swaps, output, 3 bits: swap count of the last sort, range 0..6.

Function
REQ-013 SHALL hold 4 entries of 4 bits each, plus wr_ptr (2 bits) and a full flag.
REQ-014 SHALL implement exactly three FSM states:
- IDLE
- SORT
- DONE
REQ-015 IDLE load rule: when load_valid and load_ready are both high, SHALL write Din to entry[wr_ptr] and increment wr_ptr; after the 4th write, SHALL set full (wr_ptr wraps to 0).
REQ-016 IDLE start rule: start SHALL be accepted only in IDLE with full=1; when accepted, SHALL clear swaps, pass counter and compare index j, then go to SORT. start with full=0 SHALL be ignored with no state change.
REQ-017 clear in IDLE SHALL zero wr_ptr and full; entries keep their values. clear SHALL be ignored in SORT and DONE. If clear and start are both high in IDLE, clear SHALL win.
REQ-018 SORT SHALL perform one comparison per cycle of entry[j] (DinA) against entry[j+1] (DinB) through the comparator.
- greater=1: swap the two entries at the clock edge and increment swaps.
- equal or less: no swap (stable order).
REQ-019 j SHALL step 0,1,2 and then wrap to 0; each wrap ends a pass and increments the 2-bit pass counter.
REQ-020 At the end of a pass, SHALL go to DONE if that pass (including its final compare) made no swap, or if 3 passes have completed; otherwise SHALL continue in SORT.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE with full=1, so the sorted data stays readable and can be re-sorted.
REQ-022 Latency: done SHALL be high exactly 3*P+1 cycles after the start-accepting edge, where P (1..3) is the number of passes executed.
REQ-023 load_valid, start and Din SHALL be ignored outside IDLE; Dout SHALL remain valid in every state.
REQ-024 Final order SHALL be ascending by unsigned value: entry[0] is the minimum.

Reset
REQ-025 While rst=1, at any time including mid-sort, SHALL force:
- entries to 0, wr_ptr=0, full=0, pass=0, j=0, swaps=0
- state=IDLE, busy=0, done=0
- load_ready=1
REQ-026 An interrupted sort SHALL NOT resume after reset is released.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/SORT/DONE), DEPTH=4, WIDTH=4 and MAX_PASS=3.
REQ-028 SHALL instantiate exactly one existing comparator sub-module (ports DinA, DinB, less, equal, greater); no other magnitude logic is permitted.

Verification
REQ-029 Load 10,12,15,11 then start -> entries 10,11,12,15; swaps=2; P=3; done 10 cycles after start.
REQ-030 Load 1,2,3,4 then start -> order unchanged; swaps=0; P=1; done 4 cycles after start.
REQ-031 Load 15,12,10,1 then start -> entries 1,10,12,15; swaps=6; P=3; done 10 cycles after start.
REQ-032 Load 10,10,10,10 then start -> swaps=0; done 4 cycles after start. Then clear -> load_ready=1, full=0.
REQ-033 Load only 2 values then start -> busy stays 0 and no done. After 4 loads, a 5th load_valid -> load_ready=0 and entries unchanged.
REQ-034 Assert rst on the 5th SORT cycle of the REQ-031 sort -> all outputs and entries at reset values; no done pulse follows.
